// File: rtl/day6_slot_sequencer.sv
// -----------------------------------------------------------------------------
// day6_slot_sequencer
//
// Round-robin slot sequencer that sits in front of the 3x8 decoder. It watches
// an 8-bit request vector and grants one requesting slot at a time. Each grant
// is held on the registered `state` output for DWELL cycles. After that, the
// next requester in circular order (starting after the last grant) is chosen.
//
// Parameters
//   DWELL      cycles each grant is held, 1..256 (loaded into an 8-bit counter
//              as DWELL-1)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   enable     allows new grants; sampled every cycle
//   req[7:0]   per-slot request, bit i requests slot i
//   state[2:0] currently granted slot index (to decoder)
//   valid      high while `state` is a live grant
//   slot_done  one-cycle pulse on the final dwell cycle of a grant
//   busy       high while ACTIVE, identical to valid
// -----------------------------------------------------------------------------
module day6_slot_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [2:0] state,
  output logic       valid,
  output logic       slot_done,
  output logic       busy
);

  // state  | meaning
  // IDLE   | no live grant; waiting for enable with a non-zero req
  // ACTIVE | a slot is granted; cnt counts remaining dwell cycles down to 0
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } fsm_t;

  localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);

  fsm_t       fsm_q, fsm_d;
  logic [2:0] state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic       slot_done_q, slot_done_d;

  logic [2:0] winner;
  logic       grant_ok;
  logic       dwell_end;

  assign grant_ok  = enable && (req != 8'd0);
  assign dwell_end = (cnt_q == 8'd0);

  // Scan last+8 down to last+1 so that the closest requester after `last`
  // overwrites the others. last+8 wraps to `last` itself, which makes a sole
  // requester win again.
  always_comb begin
    winner = last_q;
    for (int k = 8; k >= 1; k--) begin
      if (req[last_q + 3'(k)]) begin
        winner = last_q + 3'(k);
      end
    end
  end

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      state_q     <= 3'd0;
      last_q      <= 3'd7;
      cnt_q       <= 8'd0;
      valid_q     <= 1'b0;
      slot_done_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      slot_done_q <= slot_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: begin
        if (grant_ok) fsm_d = ACTIVE;
      end
      ACTIVE: begin
        // A grant always runs to completion; enable/req only matter at its end.
        if (dwell_end && !grant_ok) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and grant bookkeeping
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    slot_done_d = 1'b0;
    valid_d     = (fsm_d == ACTIVE);

    if ((fsm_q == IDLE) || dwell_end) begin
      if (grant_ok) begin
        state_d     = winner;
        last_d      = winner;
        cnt_d       = CNT_LOAD;
        // With DWELL=1 the very first cycle of a grant is also its last.
        slot_done_d = (CNT_LOAD == 8'd0);
      end
    end else begin
      cnt_d       = cnt_q - 8'd1;
      slot_done_d = (cnt_q == 8'd1);
    end
  end

  // Outputs come straight from flops
  always_comb begin
    state     = state_q;
    valid     = valid_q;
    busy      = valid_q;
    slot_done = slot_done_q;
  end

endmodule

// File: tb/tb_day6_slot_sequencer.sv
module tb_day6_slot_sequencer;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       enable;
  logic [7:0] req;

  logic [2:0] st [NI];
  logic       vl [NI];
  logic       sd [NI];
  logic       bs [NI];

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model per instance
  int m_active [NI];
  int m_slot   [NI];
  int m_rem    [NI];
  int m_last   [NI];

  day6_slot_sequencer #(.DWELL(4)) u_dw4 (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .state(st[0]), .valid(vl[0]), .slot_done(sd[0]), .busy(bs[0]));

  day6_slot_sequencer #(.DWELL(1)) u_dw1 (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .state(st[1]), .valid(vl[1]), .slot_done(sd[1]), .busy(bs[1]));

  day6_slot_sequencer #(.DWELL(256)) u_dw256 (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .state(st[2]), .valid(vl[2]), .slot_done(sd[2]), .busy(bs[2]));

  function automatic int dwell_of(int i);
    case (i)
      0: return 4;
      1: return 1;
      default: return 256;
    endcase
  endfunction

  // first requester strictly after `last` going round the ring, `last` itself last
  function automatic int next_winner(int last, logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (last + k) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_active[i] = 0; m_slot[i] = 0; m_rem[i] = 0; m_last[i] = 7;
      end else if (m_active[i] != 0 && m_rem[i] > 1) begin
        m_rem[i] = m_rem[i] - 1;
      end else if (enable && req != 8'd0) begin
        m_slot[i]   = next_winner(m_last[i], req);
        m_last[i]   = m_slot[i];
        m_rem[i]    = dwell_of(i);
        m_active[i] = 1;
      end else begin
        m_active[i] = 0;
        m_rem[i]    = 0;
      end
    end
  endtask

  task automatic check(string tag, int inst, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dw=%0d] t=%0t observed=%0h expected=%0h", tag, dwell_of(inst), $time, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NI; i++) begin
      logic exp_done;
      exp_done = (m_active[i] != 0) && (m_rem[i] == 1);
      check("state",     i, 8'(st[i]), 8'(m_slot[i]));
      check("valid",     i, 8'(vl[i]), 8'(m_active[i] != 0));
      check("busy",      i, 8'(bs[i]), 8'(m_active[i] != 0));
      check("slot_done", i, 8'(sd[i]), 8'(exp_done));
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < NI; i++) begin
      m_active[i] = 0; m_slot[i] = 0; m_rem[i] = 0; m_last[i] = 7;
    end

    // reset held with everything requesting
    reset = 1'b1; enable = 1'b1; req = 8'hFF;
    repeat (3) begin
      step();
      check("rst_state", 0, 8'(st[0]), 8'd0);
      check("rst_valid", 0, 8'(vl[0]), 8'd0);
      check("rst_done",  0, 8'(sd[0]), 8'd0);
    end

    // first grant right after release is slot 0
    reset = 1'b0;
    step();
    check("first_grant", 0, {4'd0, vl[0], st[0]}, 8'h08);

    // full rotation
    repeat (40) step();

    // wrap-around and skip
    req = 8'h81;
    repeat (24) step();

    // sole requester
    req = 8'h10;
    repeat (20) step();
    check("sole_slot", 0, 8'(st[0]), 8'd4);

    // drop req of the current slot in cycle 1 of a grant
    req = 8'hFF;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (m_active[0] != 0 && m_rem[0] == 4) found = 1;
    end
    check("wait_grant_start", 0, 8'(found), 8'd1);
    req = 8'hFF & ~(8'd1 << st[0]);
    repeat (6) step();

    // drop enable mid-grant
    req = 8'hFF;
    step();
    enable = 1'b0;
    repeat (8) step();
    check("en_drop_idle", 0, 8'(vl[0]), 8'd0);

    // reset at cycle 2 of a grant
    enable = 1'b1;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (m_active[0] != 0 && m_rem[0] == 3) found = 1;
    end
    check("wait_cycle2", 0, 8'(found), 8'd1);
    reset = 1'b1;
    step();
    check("midrst_valid", 0, 8'(vl[0]), 8'd0);
    check("midrst_state", 0, 8'(st[0]), 8'd0);
    check("midrst_done",  0, 8'(sd[0]), 8'd0);
    reset = 1'b0;

    // DWELL=1 alternation on slots 0 and 2
    req = 8'h05;
    repeat (12) begin
      step();
      check("dw1_done", 1, 8'(sd[1]), 8'd1);
    end

    // randomized traffic
    for (int n = 0; n < 2200; n++) begin
      case ($urandom_range(0, 5))
        0:       req = 8'd0;
        1:       req = 8'd1 << $urandom_range(0, 7);
        default: req = 8'($urandom);
      endcase
      enable = ($urandom_range(0, 7) != 0);
      reset  = ($urandom_range(0, 799) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
